countdown: RTL and testbench
============================

COUNTDOWN -- requirements
Module: countdown

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have the port ld, input, 1 bit: synchronous preset load of hour_in/min_in/sec_in.
REQ-004 The block SHALL have the port hour_in, input, 5 bits: preset hours, legal 0..23.
REQ-005 The block SHALL have the port min_in, input, 6 bits: preset minutes, legal 0..59.
REQ-006 The block SHALL have the port sec_in, input, 6 bits: preset seconds, legal 0..59.
REQ-007 The block SHALL have the port ci, input, 1 bit: count enable; one decrement per clock edge while high.
REQ-008 The block SHALL have the port co, output, 1 bit: registered expire pulse (borrow out).
REQ-009 The block SHALL have the port busy, output, 1 bit: high while in state RUN.
REQ-010 The block SHALL have the port hour_out, output, 5 bits: current hours.
REQ-011 The block SHALL have the port min_out, output, 6 bits: current minutes.
REQ-012 The block SHALL have the port sec_out, output, 6 bits: current seconds.

Function
REQ-013 The block SHALL implement the states IDLE (count zero, never run), RUN (count nonzero) and DONE (reached zero by decrement).
REQ-014 On a clock edge with ld=1, the block SHALL load the presets in any state; ld SHALL have priority over ci.
REQ-015 Out-of-range presets SHALL be clamped per field: hour_in>23 loads 23; min_in>59 and sec_in>59 load 59.
REQ-016 After a load, the block SHALL enter RUN if the loaded value is nonzero, else IDLE.
REQ-017 co SHALL be 0 on any cycle following a load.
REQ-018 In RUN with ci=1 and ld=0, sec SHALL decrement when sec>0.
REQ-019 In RUN with ci=1 and ld=0, sec 0 SHALL go to 59 with min decremented.
REQ-020 In RUN with ci=1 and ld=0, min 0 with sec 0 SHALL go to min 59, sec 59, with hour decremented.
REQ-021 Hour SHALL never underflow, because RUN is never entered at 00:00:00.
REQ-022 When a decrement produces 00:00:00, the block SHALL enter DONE and assert co for exactly the one cycle in which the outputs first show 00:00:00.
REQ-023 In RUN with ci=0, the count and state SHALL hold and co SHALL be 0.
REQ-024 In IDLE and DONE, ci SHALL be ignored: the count stays 00:00:00, there is no wrap to 23:59:59, and co=0 after the expire cycle.
REQ-025 DONE SHALL persist until ld or reset.
REQ-026 busy SHALL be 1 exactly in RUN and registered; latency from the ld edge is 1 clock.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 While rst=0, regardless of clock, the block SHALL immediately force state IDLE, hour_out=0, min_out=0, sec_out=0, co=0 and busy=0.
REQ-029 Assertion of rst mid-count or during the co cycle SHALL abort the count and drop co at once.
REQ-030 After rst returns to 1, the block SHALL remain in IDLE until ld.

Verification
REQ-031 Reset scenario: rst pulsed low mid-cycle -> all outputs 0 and busy=0 asynchronously, before the next clk edge.
REQ-032 Basic expiry: ld 00:00:03, then ci=1 for 5 clocks -> 00:00:02, 00:00:01, 00:00:00 with co=1 on that cycle only, then hold 00:00:00 with co=0 and busy=0.
REQ-033 Borrow chain: ld 11:00:00, then ci=1 for 1 clock -> 10:59:59 with busy=1 and co=0.
REQ-034 Clamp and priority: ld=1 and ci=1 together with 31:63:60 -> 23:59:59 loaded with no decrement; a subsequent ci -> 23:59:58.
REQ-035 Pause and zero load: in RUN, ci=0 for 3 clocks -> count unchanged; ld 00:00:00 -> IDLE with busy=0, and ci -> no change and co=0.
REQ-036 Reset mid-run: ld 00:01:00, 10 ci clocks, then rst low -> 00:00:00 in IDLE; after release, ci -> no change.

Source files
------------

// File: rtl/countdown.sv
// Preset hours:minutes:seconds down-counter with an IDLE/RUN/DONE controller.
// It emits a one-cycle registered borrow pulse when the count is decremented to zero.
module countdown (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [4:0] hour_in,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       ci,
  output logic       co,
  output logic       busy,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        co_q, co_d;
  logic        busy_q, busy_d;

  logic [4:0]  hour_clamp_s;
  logic [5:0]  min_clamp_s;
  logic [5:0]  sec_clamp_s;
  logic        load_nonzero_s;
  logic        last_tick_s;

  // Clamp the presets field by field before they are loaded.
  always_comb begin
    hour_clamp_s   = (hour_in > 5'd23) ? 5'd23 : hour_in;
    min_clamp_s    = (min_in  > 6'd59) ? 6'd59 : min_in;
    sec_clamp_s    = (sec_in  > 6'd59) ? 6'd59 : sec_in;
    load_nonzero_s = ({hour_clamp_s, min_clamp_s, sec_clamp_s} != 17'd0);
    last_tick_s    = (state_q == RUN) && ci && ({hour_q, min_q, sec_q} == 17'd1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a load overrides everything.
  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = load_nonzero_s ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = last_tick_s ? DONE : RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Count datapath and output decode; RUN is never entered at zero, so hours cannot underflow.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    co_d   = 1'b0;
    if (ld) begin
      hour_d = hour_clamp_s;
      min_d  = min_clamp_s;
      sec_d  = sec_clamp_s;
    end else if ((state_q == RUN) && ci) begin
      co_d = last_tick_s;
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 6'd0) begin
        sec_d = 6'd59;
        min_d = min_q - 6'd1;
      end else begin
        sec_d  = 6'd59;
        min_d  = 6'd59;
        hour_d = hour_q - 5'd1;
      end
    end else begin
      co_d = 1'b0;
    end
    busy_d = (state_d == RUN);
  end

  // Output and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q <= 5'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      co_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      co_q   <= co_d;
      busy_q <= busy_d;
    end
  end

  assign hour_out = hour_q;
  assign min_out  = min_q;
  assign sec_out  = sec_q;
  assign co       = co_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_countdown.sv
// Directed testbench for countdown: linear steps with hand-computed expectations.
module tb_countdown;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [4:0] hour_in;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       ci;
  logic       co;
  logic       busy;
  logic [4:0] hour_out;
  logic [5:0] min_out;
  logic [5:0] sec_out;

  int n_checks;
  int n_fail;

  countdown dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .hour_in  (hour_in),
    .min_in   (min_in),
    .sec_in   (sec_in),
    .ci       (ci),
    .co       (co),
    .busy     (busy),
    .hour_out (hour_out),
    .min_out  (min_out),
    .sec_out  (sec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Compare {hour,min,sec,co,busy} against an expected tuple.
  task automatic chk(input string tag, input logic [4:0] eh, input logic [5:0] em,
                     input logic [5:0] es, input logic eco, input logic ebusy);
    logic [18:0] obs;
    logic [18:0] exp;
    obs = {hour_out, min_out, sec_out, co, busy};
    exp = {eh, em, es, eco, ebusy};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d:%0d:%0d co=%b busy=%b, expected %0d:%0d:%0d co=%b busy=%b",
             tag, hour_out, min_out, sec_out, co, busy, eh, em, es, eco, ebusy);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                      input logic c);
    ld = 1'b1; hour_in = h; min_in = m; sec_in = s; ci = c;
    step();
    ld = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; ld = 1'b0; ci = 1'b0;
    hour_in = 5'd0; min_in = 6'd0; sec_in = 6'd0;
    step(); step();
    chk("reset_state", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    rst = 1'b1;
    ci = 1'b1;
    step();
    chk("idle_after_reset_ci", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Basic expiry from 00:00:03.
    ci = 1'b0;
    load(5'd0, 6'd0, 6'd3, 1'b0);
    chk("load_3s", 5'd0, 6'd0, 6'd3, 1'b0, 1'b1);
    ci = 1'b1;
    step(); chk("exp_2", 5'd0, 6'd0, 6'd2, 1'b0, 1'b1);
    step(); chk("exp_1", 5'd0, 6'd0, 6'd1, 1'b0, 1'b1);
    step(); chk("exp_0_co", 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    step(); chk("done_hold_a", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    step(); chk("done_hold_b", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Borrow chain through minutes and hours.
    load(5'd11, 6'd0, 6'd0, 1'b0);
    chk("load_11h", 5'd11, 6'd0, 6'd0, 1'b0, 1'b1);
    ci = 1'b1;
    step(); chk("borrow_hour", 5'd10, 6'd59, 6'd59, 1'b0, 1'b1);
    load(5'd2, 6'd5, 6'd0, 1'b1);
    chk("load_with_ci", 5'd2, 6'd5, 6'd0, 1'b0, 1'b1);
    step(); chk("borrow_min", 5'd2, 6'd4, 6'd59, 1'b0, 1'b1);

    // Clamp and ld-over-ci priority.
    load(5'd31, 6'd63, 6'd60, 1'b1);
    chk("clamp_load", 5'd23, 6'd59, 6'd59, 1'b0, 1'b1);
    step(); chk("clamp_dec", 5'd23, 6'd59, 6'd58, 1'b0, 1'b1);

    // Pause, then zero load.
    ci = 1'b0;
    step(); chk("pause_1", 5'd23, 6'd59, 6'd58, 1'b0, 1'b1);
    step(); chk("pause_2", 5'd23, 6'd59, 6'd58, 1'b0, 1'b1);
    step(); chk("pause_3", 5'd23, 6'd59, 6'd58, 1'b0, 1'b1);
    load(5'd0, 6'd0, 6'd0, 1'b0);
    chk("zero_load", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    ci = 1'b1;
    step(); chk("zero_load_ci", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Load arriving right after the co cycle clears co.
    load(5'd0, 6'd0, 6'd1, 1'b1);
    chk("load_1s", 5'd0, 6'd0, 6'd1, 1'b0, 1'b1);
    step(); chk("exp_from_1", 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    load(5'd0, 6'd0, 6'd2, 1'b1);
    chk("reload_from_done", 5'd0, 6'd0, 6'd2, 1'b0, 1'b1);

    // Reset during the co cycle drops co immediately.
    load(5'd0, 6'd0, 6'd1, 1'b1);
    step(); chk("co_before_rst", 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk("rst_during_co", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    rst = 1'b1;

    // Reset mid-run.
    load(5'd0, 6'd1, 6'd0, 1'b0);
    ci = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("run_10", 5'd0, 6'd0, 6'd50, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async_rst_midrun", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step(); chk("idle_after_release", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    step(); chk("idle_after_release_2", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
